abs_unit_pipe: RTL and testbench
================================

# abs_unit_pipe

Parametrised, pipelined sign-conditioning unit for the signed multiply/divide datapath. It takes CHANNELS two's-complement operands per transaction and returns, per channel, a magnitude, a negation, a sign-restored result or a pass-through. It also reports the original operand signs, the combined result sign and per-lane overflow. The unit sits in front of the unsigned mul/div core (MAG mode) and behind it (RESTORE mode), and uses valid/ready flow control on both sides.

## Interface
- WIDTH, 32, operand width in bits (≥2)
- CHANNELS, 2, lanes per transaction (≥1)
- SAT, 0, 1 = saturate on overflow; 0 = wrap (modulo 2^WIDTH) and flag
- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input transaction valid
- in_ready  out  1  unit can accept this cycle
- in_data  in  CHANNELS*WIDTH  lane i at [i*WIDTH +: WIDTH]
- mode  in  2  00 MAG, 01 NEG, 10 RESTORE, 11 PASS; sampled with in_data
- sign_in  in  CHANNELS  RESTORE only: 1 = negate lane i
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts
- out_data  out  CHANNELS*WIDTH  lane results
- out_sign  out  CHANNELS  MSB of each original input lane
- out_sign_xor  out  1  XOR of out_sign (product/quotient sign)
- out_ovf  out  CHANNELS  per-lane overflow
- ovf_sticky  out  1  OR of all delivered out_ovf since reset or clr
- clr  in  1  synchronous clear of ovf_sticky

## Operation
- Negation is ~x+1 truncated to WIDTH. MIN = 1<<(WIDTH-1); MAXP = MIN-1.
- MAG: result = MSB ? -x : x. When x==MIN, ovf=1 and the result is MIN (SAT=0) or MAXP (SAT=1).
- NEG: result = -x. When x==MIN, ovf=1 and the result is MIN (SAT=0) or MAXP (SAT=1).
- RESTORE: x is an unsigned magnitude.
  - sign_in=0: result = x. If x[MSB]=1, ovf=1 and the result is x (SAT=0) or MAXP (SAT=1).
  - sign_in=1: result = -x. If x>MIN, ovf=1 and the result is -x (SAT=0) or MIN (SAT=1). x==MIN yields MIN with no overflow.
- PASS: result = x and ovf=0.
- out_sign[i] = in lane i MSB in every mode. out_sign_xor = ^out_sign.
- ovf_sticky is set when a transfer with |out_ovf completes (out_valid && out_ready).
- clr has priority over a set in the same cycle.

## Timing
- Two register stages. S1 captures in_data, mode and sign_in. S2 holds the lane results.
- An accepted input appears on out_valid 2 cycles later when there is no backpressure. Throughput is 1 transaction per cycle.
- Stage advance conditions:
  - adv2 = !s2_valid || out_ready
  - adv1 = !s1_valid || adv2
  - in_ready = adv1. This is a combinational path from out_ready to in_ready and is permitted.
- While out_valid && !out_ready, out_data, out_sign, out_sign_xor and out_ovf hold stable.
- Simultaneous accept and deliver in the same cycle occurs with no bubble.
- in_valid with in_ready=0 does nothing. The producer must hold its data.
- Reset values: s1_valid=0, s2_valid=0, out_valid=0, out_data=0, out_sign=0, out_sign_xor=0, out_ovf=0, ovf_sticky=0. in_ready=1 during and after reset.
- Reset mid-operation discards all in-flight transactions. No partial output is produced.

## Structure
- Package abs_pkg holds:
  - mode localparams MODE_MAG, MODE_NEG, MODE_RESTORE, MODE_PASS
  - a shared negate function
- Sub-module abs_lane: combinational, one lane (x, mode, sign_in, SAT → result, ovf). It is instantiated CHANNELS times in a generate loop between S1 and S2.
- All registers live in abs_unit_pipe.

## Test plan
- WIDTH=32, CHANNELS=2, MAG, lanes {-5, 7}: out_data={5,7}, out_sign=10, out_sign_xor=1, out_ovf=00, 2 cycles after accept.
- MAG lane 0x80000000: SAT=0 gives 0x80000000 with ovf=1; SAT=1 gives 0x7FFFFFFF with ovf=1. ovf_sticky is set after delivery, then cleared by clr.
- RESTORE with sign_in=1 on x=0x80000000: result 0x80000000, ovf=0. With x=0x80000001: ovf=1, and SAT=1 gives 0x80000000.
- Back-to-back stream of 8 transactions with out_ready held 0 for 3 cycles mid-stream: no loss, no duplication, in-order delivery, in_ready=0 while both stages are full, output stable while stalled.
- rst asserted with both stages full: next cycle out_valid=0, in_ready=1, all outputs 0. No stale transaction appears afterwards.
- PASS and NEG on random values against a reference model, with CHANNELS=4 and WIDTH=8 also built and run.

Source files
------------

// File: rtl/abs_pkg.sv
// Shared definitions for the sign-conditioning pipeline: operation codes and
// the two's-complement negate helper used by every lane.
package abs_pkg;

   localparam logic [1:0] MODE_MAG     = 2'b00;
   localparam logic [1:0] MODE_NEG     = 2'b01;
   localparam logic [1:0] MODE_RESTORE = 2'b10;
   localparam logic [1:0] MODE_PASS    = 2'b11;

   // Lanes up to this width are supported; callers truncate the result back to their own width.
   localparam int NEG_MAX_WIDTH = 64;

   function automatic logic [NEG_MAX_WIDTH-1:0] negate(input logic [NEG_MAX_WIDTH-1:0] x);
      return ~x + NEG_MAX_WIDTH'(1);
   endfunction

endpackage

// File: rtl/abs_lane.sv
// One combinational lane: magnitude / negate / sign-restore / pass-through of a
// WIDTH-bit operand, with overflow detection and optional saturation.
module abs_lane
   import abs_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter bit SAT   = 1'b0
) (
   input  logic [WIDTH-1:0] x_i,
   input  logic [1:0]       mode_i,
   input  logic             sign_i,
   output logic [WIDTH-1:0] result_o,
   output logic             ovf_o
);

   localparam logic [WIDTH-1:0] MIN  = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH-1:0] MAXP = {1'b0, {(WIDTH-1){1'b1}}};

   logic [WIDTH-1:0] neg_x;
   logic             is_min;

   assign neg_x  = WIDTH'(negate(NEG_MAX_WIDTH'(x_i)));
   assign is_min = (x_i == MIN);

   always_comb begin
      result_o = x_i;
      ovf_o    = 1'b0;
      case (mode_i)
         MODE_MAG: begin
            if (x_i[WIDTH-1]) begin
               result_o = neg_x;
               if (is_min) begin
                  ovf_o = 1'b1;
                  if (SAT) result_o = MAXP;
               end
            end
         end
         MODE_NEG: begin
            result_o = neg_x;
            if (is_min) begin
               ovf_o = 1'b1;
               if (SAT) result_o = MAXP;
            end
         end
         MODE_RESTORE: begin
            // x is an unsigned magnitude here; -MIN is representable, anything larger is not.
            if (sign_i) begin
               result_o = neg_x;
               if (x_i > MIN) begin
                  ovf_o = 1'b1;
                  if (SAT) result_o = MIN;
               end
            end else if (x_i[WIDTH-1]) begin
               ovf_o = 1'b1;
               if (SAT) result_o = MAXP;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/abs_unit_pipe.sv
// Two-stage valid/ready pipeline around CHANNELS abs_lane instances: S1 registers
// the request, S2 registers lane results, signs and overflow flags.
module abs_unit_pipe
   import abs_pkg::*;
#(
   parameter int WIDTH    = 32,
   parameter int CHANNELS = 2,
   parameter bit SAT      = 1'b0
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [CHANNELS*WIDTH-1:0] in_data,
   input  logic [1:0]                mode,
   input  logic [CHANNELS-1:0]       sign_in,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [CHANNELS*WIDTH-1:0] out_data,
   output logic [CHANNELS-1:0]       out_sign,
   output logic                      out_sign_xor,
   output logic [CHANNELS-1:0]       out_ovf,
   output logic                      ovf_sticky,
   input  logic                      clr
);

   // Handshake: a beat transfers on a rising edge where valid && ready are both high;
   // a producer holding valid must keep its payload stable until that edge.
   logic                      s1_valid_q, s1_valid_d;
   logic [CHANNELS*WIDTH-1:0] s1_data_q,  s1_data_d;
   logic [1:0]                s1_mode_q,  s1_mode_d;
   logic [CHANNELS-1:0]       s1_sign_q,  s1_sign_d;

   logic                      s2_valid_q, s2_valid_d;
   logic [CHANNELS*WIDTH-1:0] s2_data_q,  s2_data_d;
   logic [CHANNELS-1:0]       s2_sign_q,  s2_sign_d;
   logic [CHANNELS-1:0]       s2_ovf_q,   s2_ovf_d;
   logic                      sticky_q,   sticky_d;

   logic                      adv1, adv2;
   logic [CHANNELS*WIDTH-1:0] lane_res;
   logic [CHANNELS-1:0]       lane_ovf;
   logic [CHANNELS-1:0]       lane_msb;

   assign adv2 = !s2_valid_q || out_ready;
   assign adv1 = !s1_valid_q || adv2;
   // Reset empties both stages, so the unit reports itself ready while reset is held.
   assign in_ready = rst || adv1;

   for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
      abs_lane #(
         .WIDTH (WIDTH),
         .SAT   (SAT)
      ) u_lane (
         .x_i      (s1_data_q[i*WIDTH +: WIDTH]),
         .mode_i   (s1_mode_q),
         .sign_i   (s1_sign_q[i]),
         .result_o (lane_res[i*WIDTH +: WIDTH]),
         .ovf_o    (lane_ovf[i])
      );
      assign lane_msb[i] = s1_data_q[i*WIDTH + WIDTH - 1];
   end

   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_data_d  = s1_data_q;
      s1_mode_d  = s1_mode_q;
      s1_sign_d  = s1_sign_q;
      s2_valid_d = s2_valid_q;
      s2_data_d  = s2_data_q;
      s2_sign_d  = s2_sign_q;
      s2_ovf_d   = s2_ovf_q;
      sticky_d   = sticky_q;

      if (adv1) begin
         s1_valid_d = in_valid;
         if (in_valid) begin
            s1_data_d = in_data;
            s1_mode_d = mode;
            s1_sign_d = sign_in;
         end
      end

      if (adv2) begin
         s2_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            s2_data_d = lane_res;
            s2_sign_d = lane_msb;
            s2_ovf_d  = lane_ovf;
         end
      end

      if (clr) begin
         sticky_d = 1'b0;
      end else if (s2_valid_q && out_ready && (|s2_ovf_q)) begin
         sticky_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
         s1_data_q  <= '0;
         s1_mode_q  <= MODE_MAG;
         s1_sign_q  <= '0;
         s2_valid_q <= 1'b0;
         s2_data_q  <= '0;
         s2_sign_q  <= '0;
         s2_ovf_q   <= '0;
         sticky_q   <= 1'b0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_data_q  <= s1_data_d;
         s1_mode_q  <= s1_mode_d;
         s1_sign_q  <= s1_sign_d;
         s2_valid_q <= s2_valid_d;
         s2_data_q  <= s2_data_d;
         s2_sign_q  <= s2_sign_d;
         s2_ovf_q   <= s2_ovf_d;
         sticky_q   <= sticky_d;
      end
   end

   assign out_valid    = s2_valid_q;
   assign out_data     = s2_data_q;
   assign out_sign     = s2_sign_q;
   assign out_sign_xor = ^s2_sign_q;
   assign out_ovf      = s2_ovf_q;
   assign ovf_sticky   = sticky_q;

endmodule

// File: tb/tb_abs_unit_pipe.sv
// Directed bench for abs_unit_pipe: 32-bit/2-lane wrap and saturate builds side by side,
// plus an 8-bit/4-lane build, all driven from one handshake.
module tb_abs_unit_pipe;

   localparam logic [1:0] M_MAG = 2'b00;
   localparam logic [1:0] M_NEG = 2'b01;
   localparam logic [1:0] M_RES = 2'b10;
   localparam logic [1:0] M_PAS = 2'b11;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b1;
   logic        clr = 1'b0;
   logic [1:0]  mode = M_MAG;
   logic [63:0] a_data = '0;
   logic [1:0]  a_sign = '0;
   logic [31:0] c_data = '0;
   logic [3:0]  c_sign = '0;

   logic        a_in_ready, a_out_valid, a_xor, a_sticky;
   logic [63:0] a_out_data;
   logic [1:0]  a_out_sign, a_out_ovf;
   logic        b_in_ready, b_out_valid, b_xor, b_sticky;
   logic [63:0] b_out_data;
   logic [1:0]  b_out_sign, b_out_ovf;
   logic        c_in_ready, c_out_valid, c_xor, c_sticky;
   logic [31:0] c_out_data;
   logic [3:0]  c_out_sign, c_out_ovf;

   int n_assert = 0;
   int n_fail   = 0;
   logic [63:0] exp_q[$];

   always #5 clk = ~clk;

   abs_unit_pipe #(.WIDTH(32), .CHANNELS(2), .SAT(1'b0)) dut_a (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready),
      .in_data(a_data), .mode(mode), .sign_in(a_sign),
      .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data),
      .out_sign(a_out_sign), .out_sign_xor(a_xor), .out_ovf(a_out_ovf),
      .ovf_sticky(a_sticky), .clr(clr));

   abs_unit_pipe #(.WIDTH(32), .CHANNELS(2), .SAT(1'b1)) dut_b (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready),
      .in_data(a_data), .mode(mode), .sign_in(a_sign),
      .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data),
      .out_sign(b_out_sign), .out_sign_xor(b_xor), .out_ovf(b_out_ovf),
      .ovf_sticky(b_sticky), .clr(clr));

   abs_unit_pipe #(.WIDTH(8), .CHANNELS(4), .SAT(1'b0)) dut_c (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(c_in_ready),
      .in_data(c_data), .mode(mode), .sign_in(c_sign),
      .out_valid(c_out_valid), .out_ready(out_ready), .out_data(c_out_data),
      .out_sign(c_out_sign), .out_sign_xor(c_xor), .out_ovf(c_out_ovf),
      .ovf_sticky(c_sticky), .clr(clr));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One transaction on an idle pipe with out_ready high; returns with the result on the outputs.
   task automatic xact(input logic [1:0] m, input logic [63:0] ad, input logic [1:0] as,
                       input logic [31:0] cd, input logic [3:0] cs);
      mode = m; a_data = ad; a_sign = as; c_data = cd; c_sign = cs;
      in_valid = 1'b1;
      #1;
      chk("xact_in_ready", {a_in_ready, b_in_ready, c_in_ready}, 3'b111);
      tick();
      in_valid = 1'b0;
      chk("xact_not_yet_valid", a_out_valid, 1'b0);
      tick();
      chk("xact_out_valid", {a_out_valid, b_out_valid, c_out_valid}, 3'b111);
   endtask

   function automatic logic [31:0] ref32(input logic [1:0] m, input logic [31:0] x);
      return (m == M_NEG) ? 32'd0 - x : x;
   endfunction

   function automatic logic [7:0] ref8(input logic [1:0] m, input logic [7:0] x);
      return (m == M_NEG) ? 8'd0 - x : x;
   endfunction

   initial begin
      int sent, got, occ;
      logic acc, del, held_v;
      logic [63:0] held, exp_d;
      logic [31:0] x0, x1, ce, cx;
      logic [1:0] eo, es;
      logic [3:0] ceo, ces;

      // Reset state, sampled while reset is held.
      tick();
      tick();
      chk("rst_in_ready", {a_in_ready, b_in_ready, c_in_ready}, 3'b111);
      chk("rst_out_valid", {a_out_valid, b_out_valid, c_out_valid}, 3'b000);
      chk("rst_out_data", a_out_data | b_out_data | {32'd0, c_out_data}, 64'd0);
      chk("rst_flags", {a_out_sign, a_xor, a_out_ovf, a_sticky, c_out_sign, c_out_ovf}, '0);
      rst = 1'b0;
      tick();

      // MAG {lane1=7, lane0=-5}
      xact(M_MAG, {32'd7, 32'hFFFF_FFFB}, 2'b00, {8'hFF, 8'h01, 8'h7F, 8'h80}, 4'b0);
      chk("mag_data", a_out_data, {32'd7, 32'd5});
      chk("mag_sign", a_out_sign, 2'b01);
      chk("mag_xor", a_xor, 1'b1);
      chk("mag_ovf", a_out_ovf, 2'b00);
      chk("mag8_data", c_out_data, {8'h01, 8'h01, 8'h7F, 8'h80});
      chk("mag8_ovf_sign", {c_out_ovf, c_out_sign, c_xor}, {4'b0001, 4'b1001, 1'b0});
      tick();

      // MAG of MIN: wrap vs saturate, sticky set on delivery then cleared.
      xact(M_MAG, {32'd0, 32'h8000_0000}, 2'b00, 32'd0, 4'b0);
      chk("magmin_wrap", {a_out_data, 6'(a_out_ovf)}, {32'd0, 32'h8000_0000, 6'b01});
      chk("magmin_sat", {b_out_data, 6'(b_out_ovf)}, {32'd0, 32'h7FFF_FFFF, 6'b01});
      chk("sticky_before_delivery", {a_sticky, b_sticky}, 2'b00);
      tick();
      chk("sticky_set", {a_sticky, b_sticky}, 2'b11);
      clr = 1'b1;
      tick();
      clr = 1'b0;
      chk("sticky_clr", {a_sticky, b_sticky}, 2'b00);

      // RESTORE negative: lane0 x=MIN (no ovf), lane1 x=MIN+1 (ovf).
      xact(M_RES, {32'h8000_0001, 32'h8000_0000}, 2'b11, 32'd0, 4'b0);
      chk("res_neg_wrap", a_out_data, {32'h7FFF_FFFF, 32'h8000_0000});
      chk("res_neg_sat", b_out_data, {32'h8000_0000, 32'h8000_0000});
      chk("res_neg_ovf", {a_out_ovf, b_out_ovf}, 4'b1010);
      chk("res_neg_sign", {a_out_sign, a_xor}, 3'b110);
      tick();

      // RESTORE positive: lane0 magnitude too large, lane1 small.
      xact(M_RES, {32'd5, 32'h9000_0000}, 2'b00, 32'd0, 4'b0);
      chk("res_pos_wrap", a_out_data, {32'd5, 32'h9000_0000});
      chk("res_pos_sat", b_out_data, {32'd5, 32'h7FFF_FFFF});
      chk("res_pos_ovf", {a_out_ovf, b_out_ovf}, 4'b0101);
      tick();

      // PASS / NEG on random values against the reference functions.
      for (int k = 0; k < 6; k++) begin
         logic [1:0] m;
         m  = k[0] ? M_NEG : M_PAS;
         x0 = (k == 1) ? 32'h8000_0000 : $urandom;
         x1 = $urandom;
         cx = (k == 1) ? {$urandom_range(255, 0), 8'h80} : $urandom;
         xact(m, {x1, x0}, 2'($urandom_range(3, 0)), cx, 4'($urandom_range(15, 0)));
         eo = '0;
         if (m == M_NEG) eo = {x1 == 32'h8000_0000, x0 == 32'h8000_0000};
         es = {x1[31], x0[31]};
         chk("rnd32_data", a_out_data, {ref32(m, x1), ref32(m, x0)});
         chk("rnd32_flags", {a_out_ovf, a_out_sign, a_xor}, {eo, es, ^es});
         ce = '0;
         ceo = '0;
         for (int j = 0; j < 4; j++) begin
            logic [7:0] lx;
            lx = cx[j*8 +: 8];
            ce[j*8 +: 8] = ref8(m, lx);
            ceo[j] = (m == M_NEG) && (lx == 8'h80);
            ces[j] = lx[7];
         end
         chk("rnd8_data", c_out_data, ce);
         chk("rnd8_flags", {c_out_ovf, c_out_sign, c_xor}, {ceo, ces, ^ces});
         tick();
      end

      // Stream of 8 with a 3-cycle stall mid-stream.
      sent = 0; got = 0; occ = 0; held_v = 1'b0; held = '0;
      mode = M_PAS;
      for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
         out_ready = !(cyc >= 4 && cyc < 7);
         in_valid  = (sent < 8);
         a_data    = {32'(sent + 100), 32'(sent)};
         #1;
         chk("stream_in_ready", a_in_ready, !(occ == 2 && !out_ready));
         acc = in_valid && a_in_ready;
         del = a_out_valid && out_ready;
         if (a_out_valid && !out_ready) begin
            if (held_v) chk("stream_stall_hold", a_out_data, held);
            held = a_out_data;
            held_v = 1'b1;
         end else begin
            held_v = 1'b0;
         end
         if (del) begin
            exp_d = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hDEAD_BEEF_DEAD_BEEF;
            chk("stream_data", a_out_data, exp_d);
            got++;
         end
         if (acc) begin
            exp_q.push_back(a_data);
            sent++;
         end
         occ = occ + int'(acc) - int'(del);
         tick();
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      chk("stream_count", 64'(got), 64'd8);
      chk("stream_queue_empty", 64'(exp_q.size()), 64'd0);
      tick();

      // Reset with both stages full.
      out_ready = 1'b0;
      mode = M_NEG;
      a_data = {32'd3, 32'h8000_0000};
      in_valid = 1'b1;
      tick();
      a_data = {32'd4, 32'd9};
      tick();
      in_valid = 1'b0;
      chk("full_in_ready", a_in_ready, 1'b0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("midrst_valid", {a_out_valid, b_out_valid, c_out_valid}, 3'b000);
      chk("midrst_in_ready", a_in_ready, 1'b1);
      chk("midrst_data", a_out_data | b_out_data, 64'd0);
      chk("midrst_flags", {a_out_sign, a_xor, a_out_ovf, a_sticky, b_sticky}, '0);
      out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("midrst_no_stale", a_out_valid, 1'b0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
